data_offload_sync_gate: RTL and testbench
=========================================

// Module: data_offload_sync_gate
// PURPOSE
// Stage directly downstream of the data offload read path, in front of the DAC/transport sink.
// Holds the offload's AXI-Stream output until a sync event (auto, hardware or software).
// Then forwards exactly one transfer-length of beats with a generated TLAST.
// Supports oneshot and cyclic modes; reports FSM state and a sticky underflow flag.
// PARAMETERS
// DATA_WIDTH     128  stream width in bits; power of 2, >= 8
// LENGTH_WIDTH   32   width of transfer_length (bytes)
// PORTS
// clk               in   1             single clock for all logic
// reset             in   1             synchronous, active-high
// enable            in   1             arm; 0 forces IDLE at the next edge
// sync_config       in   2             0=auto, 1=hardware, 2=software, 3=reserved (treated as auto)
// sync_sw_trigger   in   1             one-cycle software trigger pulse
// sync_ext          in   1             external sync, already in clk domain; level
// oneshot_en        in   1             1=oneshot, 0=cyclic
// bypass            in   1             1=combinational pass-through; FSM held in IDLE
// transfer_length   in   LENGTH_WIDTH  bytes per transfer; 0 = until s_axis_last
// s_axis_valid/ready/data/last  in/out/in/in  1/1/DATA_WIDTH/1  from offload
// m_axis_valid/ready/data/last  out/in/out/out 1/1/DATA_WIDTH/1 to sink
// underflow_clr     in   1             clears the underflow flag
// underflow         out  1             sticky: sink ready while STREAM had no source data
// fsm_state         out  4             current state encoding, for debug readback
// BEHAVIOUR
// - Reset: state=IDLE, m_axis_valid=0, m_axis_last=0, s_axis_ready=0, underflow=0, beat counter=0.
// - States: IDLE=0, WAIT_SYNC=1, STREAM=2, DONE=3.
//   - IDLE->WAIT_SYNC when enable & !bypass.
//     - On this edge: latch sync_config, oneshot_en, beats = transfer_length >> log2(DATA_WIDTH/8).
//     - A nonzero remainder rounds beats up by one.
//   - WAIT_SYNC->STREAM on the first sync event:
//     - auto: immediately (next cycle).
//     - hardware: rising edge of sync_ext, meaning a 0 in the previous cycle and 1 now.
//     - software: sync_sw_trigger=1.
//     - Events outside WAIT_SYNC are ignored; no queuing.
//   - STREAM: the last beat transfers when the counter reaches beats-1, or when s_axis_last is set if length=0.
//     - Oneshot: after the last beat, STREAM->DONE.
//     - Cyclic: after the last beat, counter=0 and stay in STREAM. No re-sync.
//   - DONE: s_axis_ready=0; stay until enable=0, then go to IDLE.
//   - Any state -> IDLE when enable=0. This includes mid-transfer.
//     - The in-flight beat is dropped, no TLAST is generated, and the counter clears.
// - Datapath in STREAM: combinational.
//   - m_axis_valid = s_axis_valid; s_axis_ready = m_axis_ready; data passes through.
//   - m_axis_last = (cnt == beats-1), or s_axis_last when length=0.
//   - Counter advances only on m_axis_valid & m_axis_ready. Zero added latency.
// - Outside STREAM with bypass=0: m_axis_valid=0, s_axis_ready=0. Upstream is back-pressured.
// - bypass=1: all m_axis/s_axis signals are wired straight through, FSM is forced to IDLE, and underflow does not update.
// - Counter is LENGTH_WIDTH wide. beats=1 produces last on every beat.
// - Underflow: set in STREAM when m_axis_ready & !s_axis_valid.
//   - underflow_clr wins over a same-cycle set.
// - fsm_state is registered state, zero-extended to 4 bits.
// STRUCTURE
// - Package data_offload_sync_pkg:
//   - sync_mode_t enum {SYNC_AUTO, SYNC_HW, SYNC_SW}
//   - gate_state_t enum {IDLE, WAIT_SYNC, STREAM, DONE}, 4-bit encodings as above
// - Sub-module sync_edge_detect: registers sync_ext, outputs a one-cycle rising-edge pulse; reset clears the history to 0.
// TESTING
// - auto, oneshot, DATA_WIDTH=128, length=64 -> exactly 4 beats forwarded.
//   - m_axis_last on beat 4, then fsm_state=3 and s_axis_ready=0.
// - hardware mode, sync_ext held high before arm -> stays WAIT_SYNC.
//   - Drop then raise -> STREAM starts the cycle after the edge.
// - software mode: trigger pulsed in IDLE is ignored; trigger in WAIT_SYNC -> STREAM next cycle.
// - cyclic, length=40 (3 beats, rounded up) -> last on beats 3, 6 and 9; no return to WAIT_SYNC.
// - enable dropped at beat 2 of 4 -> IDLE next cycle, m_axis_valid=0.
//   - Re-arm: count restarts at 0, last on the 4th beat.
// - underflow: in STREAM, m_axis_ready=1 and s_axis_valid=0 for 1 cycle -> underflow=1 until underflow_clr.
//   - clr and a new underflow in the same cycle -> 0.

Source files
------------

// File: rtl/data_offload_sync_pkg.sv
// Shared types for the data offload sync gate: sync source selection and
// gate FSM state encodings (visible on the fsm_state debug port).
package data_offload_sync_pkg;

    typedef enum logic [1:0] {
        SYNC_AUTO = 2'd0,
        SYNC_HW   = 2'd1,
        SYNC_SW   = 2'd2
    } sync_mode_t;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        WAIT_SYNC = 4'd1,
        STREAM    = 4'd2,
        DONE      = 4'd3
    } gate_state_t;

    // The reserved encoding 3 falls back to auto sync.
    function automatic sync_mode_t decode_sync_config(input logic [1:0] cfg);
        case (cfg)
            2'd1:    return SYNC_HW;
            2'd2:    return SYNC_SW;
            default: return SYNC_AUTO;
        endcase
    endfunction

endpackage

// File: rtl/data_offload_sync_gate_sync_edge_detect.sv
// Rising-edge detector for the external sync level; one-cycle pulse when the
// input is high now and was low in the previous cycle.
module sync_edge_detect (
    input  logic clk_i,
    input  logic reset_i,
    input  logic sync_i,
    output logic rise_o
);

    logic sync_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync_q <= 1'b0;
        end else begin
            sync_q <= sync_i;
        end
    end

    assign rise_o = sync_i & ~sync_q;

endmodule

// File: rtl/data_offload_sync_gate.sv
// Gates the offload AXI-Stream until a sync event, then forwards one transfer
// length of beats with a generated TLAST (oneshot or cyclic).
module data_offload_sync_gate
    import data_offload_sync_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 128,
    parameter int unsigned LENGTH_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [1:0]              sync_config,
    input  logic                    sync_sw_trigger,
    input  logic                    sync_ext,
    input  logic                    oneshot_en,
    input  logic                    bypass,
    input  logic [LENGTH_WIDTH-1:0] transfer_length,
    input  logic                    s_axis_valid,
    output logic                    s_axis_ready,
    input  logic [DATA_WIDTH-1:0]   s_axis_data,
    input  logic                    s_axis_last,
    output logic                    m_axis_valid,
    input  logic                    m_axis_ready,
    output logic [DATA_WIDTH-1:0]   m_axis_data,
    output logic                    m_axis_last,
    input  logic                    underflow_clr,
    output logic                    underflow,
    output logic [3:0]              fsm_state
);

    localparam int unsigned BEAT_SHIFT = $clog2(DATA_WIDTH / 8);
    localparam logic [LENGTH_WIDTH-1:0] REM_MASK = LENGTH_WIDTH'((1 << BEAT_SHIFT) - 1);
    localparam logic [LENGTH_WIDTH-1:0] ONE      = LENGTH_WIDTH'(1);

    gate_state_t             state_q, state_d;
    sync_mode_t              mode_q, mode_d;
    logic                    oneshot_q, oneshot_d;
    logic                    len_zero_q, len_zero_d;
    logic [LENGTH_WIDTH-1:0] last_idx_q, last_idx_d;
    logic [LENGTH_WIDTH-1:0] cnt_q, cnt_d;
    logic                    underflow_q, underflow_d;

    logic                    sync_rise;
    logic                    rem_nz;
    logic [LENGTH_WIDTH-1:0] beats_calc;
    logic                    last_beat;
    logic                    fire;
    logic                    uf_set;

    sync_edge_detect u_sync_edge (
        .clk_i   (clk),
        .reset_i (reset),
        .sync_i  (sync_ext),
        .rise_o  (sync_rise)
    );

    // Byte length to beats, rounding a partial final beat up.
    assign rem_nz     = |(transfer_length & REM_MASK);
    assign beats_calc = (transfer_length >> BEAT_SHIFT) + LENGTH_WIDTH'(rem_nz);

    assign last_beat = len_zero_q ? s_axis_last : (cnt_q == last_idx_q);
    assign fire      = (state_q == STREAM) && !bypass && s_axis_valid && m_axis_ready;
    assign uf_set    = (state_q == STREAM) && !bypass && m_axis_ready && !s_axis_valid;

    assign m_axis_data = s_axis_data;
    assign fsm_state   = state_q;
    assign underflow   = underflow_q;

    always_comb begin
        m_axis_valid = 1'b0;
        s_axis_ready = 1'b0;
        m_axis_last  = 1'b0;
        if (bypass) begin
            m_axis_valid = s_axis_valid;
            s_axis_ready = m_axis_ready;
            m_axis_last  = s_axis_last;
        end else if (state_q == STREAM) begin
            m_axis_valid = s_axis_valid;
            s_axis_ready = m_axis_ready;
            m_axis_last  = last_beat;
        end
    end

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        oneshot_d   = oneshot_q;
        len_zero_d  = len_zero_q;
        last_idx_d  = last_idx_q;
        cnt_d       = cnt_q;
        underflow_d = underflow_clr ? 1'b0 : (underflow_q | uf_set);

        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d    = WAIT_SYNC;
                    mode_d     = decode_sync_config(sync_config);
                    oneshot_d  = oneshot_en;
                    len_zero_d = (transfer_length == '0);
                    last_idx_d = beats_calc - ONE;
                end
            end
            WAIT_SYNC: begin
                case (mode_q)
                    SYNC_HW: if (sync_rise)       state_d = STREAM;
                    SYNC_SW: if (sync_sw_trigger) state_d = STREAM;
                    default:                      state_d = STREAM;
                endcase
                cnt_d = '0;
            end
            STREAM: begin
                if (fire) begin
                    if (last_beat) begin
                        cnt_d = '0;
                        if (oneshot_q) state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + ONE;
                    end
                end
            end
            DONE: begin
                cnt_d = '0;
            end
            default: state_d = IDLE;
        endcase

        // Disarm and bypass override everything, abandoning any partial transfer.
        if (bypass || !enable) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            mode_q      <= SYNC_AUTO;
            oneshot_q   <= 1'b0;
            len_zero_q  <= 1'b0;
            last_idx_q  <= '0;
            cnt_q       <= '0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            oneshot_q   <= oneshot_d;
            len_zero_q  <= len_zero_d;
            last_idx_q  <= last_idx_d;
            cnt_q       <= cnt_d;
            underflow_q <= underflow_d;
        end
    end

endmodule

// File: tb/tb_data_offload_sync_gate.sv
// Self-checking bench for data_offload_sync_gate: table of oneshot transfers
// plus directed sequences; forwarded beats are checked against a scoreboard.
module tb_data_offload_sync_gate;

    localparam int DW = 128;
    localparam int LW = 32;

    logic          clk = 1'b0;
    logic          reset, enable, sync_sw_trigger, sync_ext, oneshot_en, bypass;
    logic [1:0]    sync_config;
    logic [LW-1:0] transfer_length;
    logic          s_axis_valid, s_axis_ready, s_axis_last;
    logic [DW-1:0] s_axis_data;
    logic          m_axis_valid, m_axis_ready, m_axis_last;
    logic [DW-1:0] m_axis_data;
    logic          underflow_clr, underflow;
    logic [3:0]    fsm_state;

    always #5 clk = ~clk;

    data_offload_sync_gate #(.DATA_WIDTH(DW), .LENGTH_WIDTH(LW)) dut (
        .clk             (clk),
        .reset           (reset),
        .enable          (enable),
        .sync_config     (sync_config),
        .sync_sw_trigger (sync_sw_trigger),
        .sync_ext        (sync_ext),
        .oneshot_en      (oneshot_en),
        .bypass          (bypass),
        .transfer_length (transfer_length),
        .s_axis_valid    (s_axis_valid),
        .s_axis_ready    (s_axis_ready),
        .s_axis_data     (s_axis_data),
        .s_axis_last     (s_axis_last),
        .m_axis_valid    (m_axis_valid),
        .m_axis_ready    (m_axis_ready),
        .m_axis_data     (m_axis_data),
        .m_axis_last     (m_axis_last),
        .underflow_clr   (underflow_clr),
        .underflow       (underflow),
        .fsm_state       (fsm_state)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    typedef struct {
        logic [1:0]    cfg;
        logic [LW-1:0] len;
        int            nbeats;
        logic          use_slast;
    } vec_t;

    beat_t         sb[$];
    vec_t          vecs[6];
    int            checks   = 0;
    int            failures = 0;
    logic [DW-1:0] next_data;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        beat_t e;
        if (m_axis_valid === 1'b1 && m_axis_ready === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_beat actual data=%h last=%0b expected no beat",
                         m_axis_data, m_axis_last);
            end else begin
                e = sb.pop_front();
                if (m_axis_data !== e.data || m_axis_last !== e.last) begin
                    failures++;
                    $display("FAIL beat actual data=%h last=%0b expected data=%h last=%0b",
                             m_axis_data, m_axis_last, e.data, e.last);
                end
            end
        end
    end

    // Offer one beat and wait (bounded) for the upstream handshake.
    task automatic send_beat(input logic slast, input logic exp_last);
        bit done = 0;
        s_axis_valid = 1'b1;
        s_axis_data  = next_data;
        s_axis_last  = slast;
        sb.push_back('{data: next_data, last: exp_last});
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            if (s_axis_ready === 1'b1) done = 1;
            tick();
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL handshake_timeout actual=no_ready expected=ready");
            void'(sb.pop_back());
        end
        next_data    = {$urandom, $urandom, $urandom, $urandom};
        s_axis_valid = 1'b0;
        s_axis_last  = 1'b0;
    endtask

    task automatic arm(input logic [1:0] cfg, input logic os, input logic [LW-1:0] len);
        enable = 1'b0;
        tick();
        sync_config     = cfg;
        oneshot_en      = os;
        transfer_length = len;
        enable          = 1'b1;
        tick();
        #1 check("arm_wait_sync", 64'(fsm_state), 64'd1);
    endtask

    task automatic run_vector(input vec_t v);
        arm(v.cfg, 1'b1, v.len);
        if (v.cfg == 2'd2) begin
            sync_sw_trigger = 1'b1;
            tick();
            sync_sw_trigger = 1'b0;
        end else begin
            tick();
        end
        #1 check("vec_stream", 64'(fsm_state), 64'd2);
        for (int i = 1; i <= v.nbeats; i++) send_beat(v.use_slast && i == v.nbeats, i == v.nbeats);
        s_axis_valid = 1'b1;
        #1;
        check("vec_done_state", 64'(fsm_state), 64'd3);
        check("vec_done_sready", 64'(s_axis_ready), 64'd0);
        check("vec_done_mvalid", 64'(m_axis_valid), 64'd0);
        s_axis_valid = 1'b0;
    endtask

    initial begin
        vecs[0] = '{cfg: 2'd0, len: 32'd64, nbeats: 4, use_slast: 1'b0};
        vecs[1] = '{cfg: 2'd0, len: 32'd16, nbeats: 1, use_slast: 1'b0};
        vecs[2] = '{cfg: 2'd0, len: 32'd17, nbeats: 2, use_slast: 1'b0};
        vecs[3] = '{cfg: 2'd2, len: 32'd48, nbeats: 3, use_slast: 1'b0};
        vecs[4] = '{cfg: 2'd0, len: 32'd0,  nbeats: 5, use_slast: 1'b1};
        vecs[5] = '{cfg: 2'd3, len: 32'd1,  nbeats: 1, use_slast: 1'b0};

        reset = 1'b1; enable = 1'b0; sync_config = 2'd0; sync_sw_trigger = 1'b0;
        sync_ext = 1'b0; oneshot_en = 1'b1; bypass = 1'b0; transfer_length = '0;
        s_axis_valid = 1'b1; s_axis_last = 1'b0; s_axis_data = '0; m_axis_ready = 1'b1;
        underflow_clr = 1'b0;
        next_data = {$urandom, $urandom, $urandom, $urandom};

        repeat (3) tick();
        #1;
        check("reset_state", 64'(fsm_state), 64'd0);
        check("reset_mvalid", 64'(m_axis_valid), 64'd0);
        check("reset_mlast", 64'(m_axis_last), 64'd0);
        check("reset_sready", 64'(s_axis_ready), 64'd0);
        check("reset_underflow", 64'(underflow), 64'd0);
        reset = 1'b0;
        s_axis_valid = 1'b0;
        tick();

        // Bypass: straight wires, FSM pinned in IDLE even with enable set.
        bypass = 1'b1; enable = 1'b1; s_axis_valid = 1'b1; s_axis_last = 1'b1;
        s_axis_data = next_data;
        sb.push_back('{data: next_data, last: 1'b1});
        #1;
        check("byp_mvalid", 64'(m_axis_valid), 64'd1);
        check("byp_sready", 64'(s_axis_ready), 64'd1);
        check("byp_mlast", 64'(m_axis_last), 64'd1);
        tick();
        #1 check("byp_idle", 64'(fsm_state), 64'd0);
        bypass = 1'b0; enable = 1'b0; s_axis_valid = 1'b0; s_axis_last = 1'b0;
        next_data = {$urandom, $urandom, $urandom, $urandom};
        tick();

        foreach (vecs[i]) run_vector(vecs[i]);

        // Cyclic, 40 bytes -> 3 beats per transfer, no re-sync between transfers.
        arm(2'd0, 1'b0, 32'd40);
        tick();
        #1 check("cyc_stream", 64'(fsm_state), 64'd2);
        for (int i = 1; i <= 9; i++) send_beat(1'b0, (i % 3) == 0);
        #1 check("cyc_still_stream", 64'(fsm_state), 64'd2);

        // Hardware sync held high before arming must not count as an edge.
        enable = 1'b0; sync_ext = 1'b1;
        repeat (2) tick();
        arm(2'd1, 1'b1, 32'd32);
        repeat (3) tick();
        #1 check("hw_level_no_sync", 64'(fsm_state), 64'd1);
        sync_ext = 1'b0;
        tick();
        #1 check("hw_low_wait", 64'(fsm_state), 64'd1);
        sync_ext = 1'b1;
        tick();
        #1 check("hw_edge_stream", 64'(fsm_state), 64'd2);
        send_beat(1'b0, 1'b0);
        send_beat(1'b0, 1'b1);
        #1 check("hw_done", 64'(fsm_state), 64'd3);
        sync_ext = 1'b0;

        // Software trigger in IDLE is not remembered.
        enable = 1'b0;
        tick();
        sync_sw_trigger = 1'b1;
        tick();
        sync_sw_trigger = 1'b0;
        #1 check("sw_idle_ignored", 64'(fsm_state), 64'd0);
        arm(2'd2, 1'b1, 32'd16);
        repeat (2) tick();
        #1 check("sw_wait_holds", 64'(fsm_state), 64'd1);
        sync_sw_trigger = 1'b1;
        tick();
        sync_sw_trigger = 1'b0;
        #1 check("sw_trigger_stream", 64'(fsm_state), 64'd2);
        send_beat(1'b0, 1'b1);
        #1 check("sw_done", 64'(fsm_state), 64'd3);

        // Disarm mid-transfer, then re-arm: counting restarts from zero.
        arm(2'd0, 1'b1, 32'd64);
        tick();
        send_beat(1'b0, 1'b0);
        send_beat(1'b0, 1'b0);
        enable = 1'b0;
        tick();
        s_axis_valid = 1'b1;
        #1;
        check("drop_idle", 64'(fsm_state), 64'd0);
        check("drop_mvalid", 64'(m_axis_valid), 64'd0);
        s_axis_valid = 1'b0;
        run_vector(vecs[0]);

        // Underflow: sticky until cleared, and clear beats a same-cycle set.
        enable = 1'b0; underflow_clr = 1'b1;
        tick();
        underflow_clr = 1'b0;
        #1 check("uf_cleared", 64'(underflow), 64'd0);
        arm(2'd0, 1'b1, 32'd64);
        tick();
        #1 check("uf_none_in_wait", 64'(underflow), 64'd0);
        tick();
        #1 check("uf_set", 64'(underflow), 64'd1);
        send_beat(1'b0, 1'b0);
        send_beat(1'b0, 1'b0);
        #1 check("uf_sticky", 64'(underflow), 64'd1);
        underflow_clr = 1'b1;
        tick();
        underflow_clr = 1'b0;
        #1 check("uf_clr_wins", 64'(underflow), 64'd0);
        send_beat(1'b0, 1'b0);
        send_beat(1'b0, 1'b1);
        #1;
        check("uf_after_clr", 64'(underflow), 64'd0);
        check("uf_done", 64'(fsm_state), 64'd3);

        enable = 1'b0;
        repeat (2) tick();
        check("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
